// File: rtl/qu_instr_decoder_pkg.sv
// Shared definitions for the Qu decode stage.
//   - optype class constants (OPTYPE_R .. OPTYPE_ILLEGAL)
//   - RV32I major opcode constants
//   - imm32_t: sign-extended 32-bit immediate
//   - decoded_instr_t: every decoded payload field except the PC
package qu_instr_decoder_pkg;

  localparam int QU_INSTR_WIDTH_DEFAULT = 32;
  localparam int QU_PC_WIDTH_DEFAULT    = 12;

  typedef logic signed [31:0] imm32_t;

  localparam logic [3:0] OPTYPE_R       = 4'd0;
  localparam logic [3:0] OPTYPE_I       = 4'd1;
  localparam logic [3:0] OPTYPE_LOAD    = 4'd2;
  localparam logic [3:0] OPTYPE_STORE   = 4'd3;
  localparam logic [3:0] OPTYPE_BRANCH  = 4'd4;
  localparam logic [3:0] OPTYPE_JAL     = 4'd5;
  localparam logic [3:0] OPTYPE_JALR    = 4'd6;
  localparam logic [3:0] OPTYPE_LUI     = 4'd7;
  localparam logic [3:0] OPTYPE_AUIPC   = 4'd8;
  localparam logic [3:0] OPTYPE_SYSCALL = 4'd9;
  localparam logic [3:0] OPTYPE_CSR     = 4'd10;
  localparam logic [3:0] OPTYPE_FENCE   = 4'd11;
  localparam logic [3:0] OPTYPE_ILLEGAL = 4'd15;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic [3:0] optype;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_valid;
    logic       rs1_valid;
    logic       rs2_valid;
    logic       imm_valid;
    imm32_t     imm;
    logic       illegal;
  } decoded_instr_t;

endpackage

// File: rtl/qu_instr_decode_comb.sv
// Purely combinational RV32I word -> decoded_instr_t.
// Ports:
//   instr  in  32  instruction word
//   dec    out     decoded fields (optype, raw fields, use flags, immediate, illegal)
module qu_instr_decode_comb
  import qu_instr_decoder_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [3:0] cls;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];

  // Class and legality. Every recognised opcode ends in 2'b11, so a word
  // with other low bits falls into the default arm and is illegal.
  always_comb begin
    cls   = OPTYPE_ILLEGAL;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls   = OPTYPE_R;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        cls = OPTYPE_I;
        // Shift-immediates reuse the funct7 slot; only SRAI may set bit 30.
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
      end
      OPC_LOAD: begin
        cls   = OPTYPE_LOAD;
        legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
      end
      OPC_STORE: begin
        cls   = OPTYPE_STORE;
        legal = (f3 <= 3'b010);
      end
      OPC_BRANCH: begin
        cls   = OPTYPE_BRANCH;
        legal = !((f3 == 3'b010) || (f3 == 3'b011));
      end
      OPC_JAL: begin
        cls   = OPTYPE_JAL;
        legal = 1'b1;
      end
      OPC_JALR: begin
        cls   = OPTYPE_JALR;
        legal = (f3 == 3'b000);
      end
      OPC_LUI: begin
        cls   = OPTYPE_LUI;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        cls   = OPTYPE_AUIPC;
        legal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          // Only ECALL (imm 0) and EBREAK (imm 1) with zero register fields.
          cls   = OPTYPE_SYSCALL;
          legal = (rd == 5'd0) && (rs1 == 5'd0) && (instr[31:21] == 11'd0);
        end else begin
          cls   = OPTYPE_CSR;
          legal = (f3 != 3'b100);
        end
      end
      OPC_MISC_MEM: begin
        cls   = OPTYPE_FENCE;
        legal = (f3 <= 3'b001);
      end
      default: begin
        cls   = OPTYPE_ILLEGAL;
        legal = 1'b0;
      end
    endcase
  end

  // Use flags and immediate. Raw register/funct fields pass through even
  // for illegal words; consumers gate on the valid flags.
  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.rd     = rd;
    dec.rs1    = rs1;
    dec.rs2    = instr[24:20];
    if (!legal) begin
      dec.optype  = OPTYPE_ILLEGAL;
      dec.illegal = 1'b1;
    end else begin
      dec.optype = cls;
      case (cls)
        OPTYPE_R: begin
          dec.rd_valid  = (rd != 5'd0);
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
        end
        OPTYPE_I, OPTYPE_LOAD, OPTYPE_JALR: begin
          dec.rd_valid  = (rd != 5'd0);
          dec.rs1_valid = 1'b1;
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({{20{instr[31]}}, instr[31:20]});
        end
        OPTYPE_STORE: begin
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({{20{instr[31]}}, instr[31:25], instr[11:7]});
        end
        OPTYPE_BRANCH: begin
          dec.rs1_valid = 1'b1;
          dec.rs2_valid = 1'b1;
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0});
        end
        OPTYPE_JAL: begin
          dec.rd_valid  = (rd != 5'd0);
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({{11{instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0});
        end
        OPTYPE_LUI, OPTYPE_AUIPC: begin
          dec.rd_valid  = (rd != 5'd0);
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({instr[31:12], 12'b0});
        end
        OPTYPE_CSR: begin
          // funct3[2] selects the immediate forms, where rs1 holds a uimm.
          dec.rd_valid  = (rd != 5'd0);
          dec.rs1_valid = !f3[2];
          dec.imm_valid = 1'b1;
          dec.imm       = imm32_t'({20'b0, instr[31:20]});
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/qu_instr_decoder.sv
// Qu registered decode stage: one RV32I instruction per cycle over a
// valid/ready handshake, decoded into a single output register.
// Ports:
//   clk, rst (sync, active-high), flush (drops held entry and same-cycle input)
//   in_valid/in_ready/in_instr/in_pc         upstream handshake and payload
//   out_valid/out_ready                      downstream handshake
//   out_optype, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
//   out_rd_valid, out_rs1_valid, out_rs2_valid, out_imm_valid,
//   out_imm, out_pc, out_illegal              registered decoded payload
//   illegal_cnt                               saturating illegal count, only
//                                             with QU_DECODER_ILLEGAL_CNT_EN
module qu_instr_decoder #(
  parameter int QU_INSTR_WIDTH = 32,  // fixed at 32
  parameter int QU_PC_WIDTH    = qu_instr_decoder_pkg::QU_PC_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [QU_INSTR_WIDTH-1:0] in_instr,
  input  logic [QU_PC_WIDTH-1:0]    in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_optype,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic                      out_rd_valid,
  output logic                      out_rs1_valid,
  output logic                      out_rs2_valid,
  output logic                      out_imm_valid,
  output logic [31:0]               out_imm,
  output logic [QU_PC_WIDTH-1:0]    out_pc,
  output logic                      out_illegal
`ifdef QU_DECODER_ILLEGAL_CNT_EN
  ,
  output logic [31:0]               illegal_cnt
`endif
);

  import qu_instr_decoder_pkg::*;

  decoded_instr_t           dec_p0;
  decoded_instr_t           dec_p1;
  logic [QU_PC_WIDTH-1:0]   pc_p1;
  logic                     vld_p1;
  logic                     take_p0;

  // ---- stage p0: combinational decode of the presented word ----
  qu_instr_decode_comb u_decode (
    .instr (in_instr),
    .dec   (dec_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  // in_ready ignores flush, but a flushed input is never captured.
  assign take_p0  = in_valid && in_ready && !flush;

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (take_p0) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Payload loads only on capture so it stays steady during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_p1 <= '0;
      pc_p1  <= '0;
    end else if (take_p0) begin
      dec_p1 <= dec_p0;
      pc_p1  <= in_pc;
    end
  end

  assign out_valid     = vld_p1;
  assign out_optype    = dec_p1.optype;
  assign out_funct3    = dec_p1.funct3;
  assign out_funct7    = dec_p1.funct7;
  assign out_rd        = dec_p1.rd;
  assign out_rs1       = dec_p1.rs1;
  assign out_rs2       = dec_p1.rs2;
  assign out_rd_valid  = dec_p1.rd_valid;
  assign out_rs1_valid = dec_p1.rs1_valid;
  assign out_rs2_valid = dec_p1.rs2_valid;
  assign out_imm_valid = dec_p1.imm_valid;
  assign out_imm       = dec_p1.imm;
  assign out_pc        = pc_p1;
  assign out_illegal   = dec_p1.illegal;

`ifdef QU_DECODER_ILLEGAL_CNT_EN
  logic [31:0] ill_cnt_p1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_cnt_p1 <= '0;
    end else if (take_p0 && dec_p0.illegal) begin
      ill_cnt_p1 <= sat_inc32(ill_cnt_p1);
    end
  end

  assign illegal_cnt = ill_cnt_p1;
`endif

endmodule

// File: tb/tb_qu_instr_decoder.sv
// Testbench for qu_instr_decoder: directed vector table, handshake corner
// sequences, then randomized traffic against a transaction-level model.
module tb_qu_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [11:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_optype;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_rd_valid;
  logic        out_rs1_valid;
  logic        out_rs2_valid;
  logic        out_imm_valid;
  logic [31:0] out_imm;
  logic [11:0] out_pc;
  logic        out_illegal;
`ifdef QU_DECODER_ILLEGAL_CNT_EN
  logic [31:0] illegal_cnt;
`endif

  always #5 clk = ~clk;

  qu_instr_decoder #(
    .QU_INSTR_WIDTH (32),
    .QU_PC_WIDTH    (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_optype    (out_optype),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd_valid  (out_rd_valid),
    .out_rs1_valid (out_rs1_valid),
    .out_rs2_valid (out_rs2_valid),
    .out_imm_valid (out_imm_valid),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
`ifdef QU_DECODER_ILLEGAL_CNT_EN
    ,
    .illegal_cnt   (illegal_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cnt_exp  = 0;

  // flags packing: {rd_valid, rs1_valid, rs2_valid, imm_valid, illegal}
  typedef struct packed {
    logic [3:0]  opt;
    logic [4:0]  flags;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opt;
    logic [31:0] imm;
    logic [4:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] pc;
  } item_t;

  vec_t  tab[$];
  item_t q[$];

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                           7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode, computed from the ISA rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    int          op, f3, f7, rd, rs1, cls, v;
    bit          ok, rdv, rs1v, rs2v, immv;
    logic [31:0] imm;
    op  = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    rd  = int'(w[11:7]);
    rs1 = int'(w[19:15]);
    cls = 15;
    ok  = 0;
    case (op)
      'h33: begin cls = 0;  ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
      'h13: begin cls = 1;  ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1; end
      'h03: begin cls = 2;  ok = f3 inside {0, 1, 2, 4, 5}; end
      'h23: begin cls = 3;  ok = f3 <= 2; end
      'h63: begin cls = 4;  ok = f3 inside {0, 1, 4, 5, 6, 7}; end
      'h6F: begin cls = 5;  ok = 1; end
      'h67: begin cls = 6;  ok = (f3 == 0); end
      'h37: begin cls = 7;  ok = 1; end
      'h17: begin cls = 8;  ok = 1; end
      'h73: begin
        if (f3 == 0) begin
          cls = 9;
          ok  = (rd == 0) && (rs1 == 0) && (int'(w[31:20]) <= 1);
        end else begin
          cls = 10;
          ok  = (f3 != 4);
        end
      end
      'h0F: begin cls = 11; ok = f3 <= 1; end
      default: begin cls = 15; ok = 0; end
    endcase
    e = '0;
    if (!ok) begin
      e.opt   = 4'hF;
      e.flags = 5'b00001;
      return e;
    end
    rdv  = (cls inside {0, 1, 2, 5, 6, 7, 8, 10}) && (rd != 0);
    rs1v = (cls inside {0, 1, 2, 3, 4, 6}) || (cls == 10 && f3 < 4);
    rs2v = cls inside {0, 3, 4};
    immv = cls inside {1, 2, 3, 4, 5, 6, 7, 8, 10};
    case (cls)
      1, 2, 6: v = int'(w[31:20]) - (w[31] ? 4096 : 0);
      3:       v = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
      4:       v = 2 * int'({w[7], w[30:25], w[11:8]}) - (w[31] ? 4096 : 0);
      5:       v = 2 * int'({w[19:12], w[20], w[30:21]}) - (w[31] ? 1048576 : 0);
      10:      v = int'(w[31:20]);
      default: v = 0;
    endcase
    imm = 32'(v);
    if (cls == 7 || cls == 8) imm = w & 32'hFFFF_F000;
    e.opt   = 4'(cls);
    e.flags = {rdv, rs1v, rs2v, immv, 1'b0};
    e.imm   = imm;
    return e;
  endfunction

  function automatic logic [4:0] dut_flags();
    return {out_rd_valid, out_rs1_valid, out_rs2_valid, out_imm_valid, out_illegal};
  endfunction

  task automatic chk_fields(input string tag, input logic [31:0] w);
    chk($sformatf("%s.funct3", tag), 32'(out_funct3), 32'(w[14:12]));
    chk($sformatf("%s.funct7", tag), 32'(out_funct7), 32'(w[31:25]));
    chk($sformatf("%s.rd", tag),     32'(out_rd),     32'(w[11:7]));
    chk($sformatf("%s.rs1", tag),    32'(out_rs1),    32'(w[19:15]));
    chk($sformatf("%s.rs2", tag),    32'(out_rs2),    32'(w[24:20]));
  endtask

  task automatic chk_out(input string tag, input logic [31:0] w, input logic [11:0] pc);
    exp_t e;
    e = ref_decode(w);
    chk($sformatf("%s.valid", tag),  32'(out_valid),  32'd1);
    chk($sformatf("%s.optype", tag), 32'(out_optype), 32'(e.opt));
    chk($sformatf("%s.flags", tag),  32'(dut_flags()), 32'(e.flags));
    chk($sformatf("%s.imm", tag),    out_imm,         e.imm);
    chk($sformatf("%s.pc", tag),     32'(out_pc),     32'(pc));
    chk_fields(tag, w);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef QU_DECODER_ILLEGAL_CNT_EN
    chk($sformatf("%s.illegal_cnt", tag), illegal_cnt, 32'(cnt_exp));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic add_vec(input logic [31:0] w, input logic [3:0] opt,
                         input logic [31:0] imm, input logic [4:0] flags);
    vec_t v;
    v.instr = w; v.opt = opt; v.imm = imm; v.flags = flags;
    tab.push_back(v);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          pick;
    w    = $urandom;
    pick = $urandom_range(0, 13);
    if (pick < 11) begin
      w[6:0] = ops[pick];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 2) != 0)
        w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 0)
        w[31:7] = {11'd0, 1'($urandom_range(0, 1)), 13'd0};
    end
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ready_exp;
    exp_t e;

    add_vec(32'h002081B3, 4'd0,  32'h0000_0000, 5'b11100); // add x3,x1,x2
    add_vec(32'hFE208EE3, 4'd4,  32'hFFFF_FFFC, 5'b01110); // beq x1,x2,-4
    add_vec(32'h123452B7, 4'd7,  32'h1234_5000, 5'b10010); // lui x5
    add_vec(32'h00000000, 4'd15, 32'h0000_0000, 5'b00001); // all zero
    add_vec(32'h4000D033, 4'd0,  32'h0000_0000, 5'b01100); // sra x0,x1,x0
    add_vec(32'h4010D093, 4'd1,  32'h0000_0401, 5'b11010); // srai x1,x1,1
    add_vec(32'h40109093, 4'd15, 32'h0000_0000, 5'b00001); // slli bad funct7
    add_vec(32'h00000073, 4'd9,  32'h0000_0000, 5'b00000); // ecall
    add_vec(32'h00100073, 4'd9,  32'h0000_0000, 5'b00000); // ebreak
    add_vec(32'h00200073, 4'd15, 32'h0000_0000, 5'b00001); // system imm 2
    add_vec(32'h3002D0F3, 4'd10, 32'h0000_0300, 5'b10010); // csrrwi x1,0x300,5
    add_vec(32'hFFF11073, 4'd10, 32'h0000_0FFF, 5'b01010); // csrrw x0,0xfff,x2
    add_vec(32'h00004073, 4'd15, 32'h0000_0000, 5'b00001); // csr funct3 100
    add_vec(32'hFFDFF06F, 4'd5,  32'hFFFF_FFFC, 5'b00010); // jal x0,-4
    add_vec(32'hFE20AFA3, 4'd3,  32'hFFFF_FFFF, 5'b01110); // sw x2,-1(x1)
    add_vec(32'h00003003, 4'd15, 32'h0000_0000, 5'b00001); // load funct3 011
    add_vec(32'h00000010, 4'd15, 32'h0000_0000, 5'b00001); // low bits 00
    add_vec(32'h00001067, 4'd15, 32'h0000_0000, 5'b00001); // jalr funct3 1
    add_vec(32'h0FF0000F, 4'd11, 32'h0000_0000, 5'b00000); // fence
    add_vec(32'hFFFFF117, 4'd8,  32'hFFFF_F000, 5'b10010); // auipc x2
    add_vec(32'hFFF10083, 4'd2,  32'hFFFF_FFFF, 5'b11010); // lb x1,-1(x2)
    add_vec(32'h008280E7, 4'd6,  32'h0000_0008, 5'b11010); // jalr x1,8(x5)

    // Reset state
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 12'h0;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd1);
    chk("reset.optype",    32'(out_optype), 32'd0);
    chk("reset.flags",     32'(dut_flags()), 32'd0);
    chk("reset.imm",       out_imm, 32'd0);
    chk("reset.pc",        32'(out_pc), 32'd0);
    chk("reset.rd",        32'(out_rd), 32'd0);
    chk_cnt("reset");
    rst = 1'b0;

    // Directed table at full throughput
    out_ready = 1'b1;
    foreach (tab[i]) begin
      in_valid = 1'b1;
      in_instr = tab[i].instr;
      in_pc    = 12'(i + 16);
      @(negedge clk);
      if (tab[i].flags[0]) cnt_exp++;
      chk($sformatf("vec%0d.valid", i),  32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.optype", i), 32'(out_optype), 32'(tab[i].opt));
      chk($sformatf("vec%0d.imm", i),    out_imm, tab[i].imm);
      chk($sformatf("vec%0d.flags", i),  32'(dut_flags()), 32'(tab[i].flags));
      chk($sformatf("vec%0d.pc", i),     32'(out_pc), 32'(i + 16));
      chk_fields($sformatf("vec%0d", i), tab[i].instr);
      chk_cnt($sformatf("vec%0d", i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Stall: downstream not ready for two cycles
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 12'h001;
    @(negedge clk);
    chk_out("stall.a", 32'h002081B3, 12'h001);
    in_instr = 32'hFE208EE3; in_pc = 12'h002;
    #1;
    chk("stall.in_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'd0);
      chk_out($sformatf("stall%0d.hold", k), 32'h002081B3, 12'h001);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.in_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk_out("stall.b", 32'hFE208EE3, 12'h002);
    in_instr = 32'h123452B7; in_pc = 12'h003;
    @(negedge clk);
    chk_out("stall.c", 32'h123452B7, 12'h003);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall.empty", 32'(out_valid), 32'd0);

    // Flush with a held entry and an illegal input in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h4010D093; in_pc = 12'h004;
    @(negedge clk);
    chk_out("flush.held", 32'h4010D093, 12'h004);
    out_ready = 1'b1; flush = 1'b1; in_instr = 32'h00000000; in_pc = 12'h005;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk_cnt("flush");
    @(negedge clk);
    chk("flush.never", 32'(out_valid), 32'd0);

    // Reset while an entry is stalled
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 12'h006;
    @(negedge clk);
    chk_out("rstmid.held", 32'h00000000, 12'h006);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt_exp = 0;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.optype",    32'(out_optype), 32'd0);
    chk("rstmid.flags",     32'(dut_flags()), 32'd0);
    chk("rstmid.pc",        32'(out_pc), 32'd0);
    chk_cnt("rstmid");

    // Randomized traffic against the transaction-level model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = rand_instr();
      in_pc     = 12'($urandom);
      #1;
      ready_exp = (q.size() == 0) || out_ready;
      chk($sformatf("rnd%0d.in_ready", c),  32'(in_ready),  32'(ready_exp));
      chk($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk_out($sformatf("rnd%0d", c), q[0].instr, q[0].pc);
      chk_cnt($sformatf("rnd%0d", c));
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && ready_exp) begin
          item_t it;
          it.instr = in_instr;
          it.pc    = in_pc;
          q.push_back(it);
          e = ref_decode(in_instr);
          if (e.flags[0]) cnt_exp++;
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qu_instr_decoder.md
# qu_instr_decoder

Registered decode stage of the Qu processor, between instruction fetch and rename/reservation-station dispatch. It accepts one 32-bit RV32I instruction per cycle with its PC over a valid/ready handshake. It splits the word into register addresses, a sign-extended immediate, operand-valid flags and an operation class, and flags illegal encodings. It is the inverse of the team's instruction-encoding helpers: any word those helpers produce decodes back to the same fields.

## Interface
- `QU_INSTR_WIDTH`, default 32: instruction width. Fixed; any other value is unsupported.
- `QU_PC_WIDTH`, default 12: PC width, from the shared package.
- `clk`  in  1: clock.
- `rst`  in  1: reset. **One clock; reset is synchronous and active-high.**
- `flush`  in  1: discard the held output and the input presented in the same cycle.
- `in_valid`  in  1: an instruction is present.
- `in_ready`  out  1: the stage accepts the instruction this cycle.
- `in_instr`  in  32: instruction word.
- `in_pc`  in  `QU_PC_WIDTH`: PC of the instruction.
- `out_valid`  out  1: decoded fields are valid.
- `out_ready`  in  1: downstream accepts this cycle.
- `out_optype`  out  4: operation class (see Operation).
- `out_funct3`  out  3: instr[14:12].
- `out_funct7`  out  7: instr[31:25].
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each: register fields.
- `out_rd_valid`, `out_rs1_valid`, `out_rs2_valid`, `out_imm_valid`  out  1 each: field-use flags.
- `out_imm`  out  32: sign-extended immediate.
- `out_pc`  out  `QU_PC_WIDTH`: registered PC.
- `out_illegal`  out  1: illegal encoding.
- `illegal_cnt`  out  32: illegal-instruction count. Exists only with `QU_DECODER_ILLEGAL_CNT_EN` (see Configuration).

## Operation
- Optype encoding:
  - 0 R, 1 I (OP-IMM), 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC.
  - 9 SYSCALL: opcode 1110011 with funct3 000.
  - 10 CSR: opcode 1110011 with funct3 ≠ 000.
  - 11 FENCE.
  - 15 ILLEGAL.
- Immediate by class:
  - I/LOAD/JALR: sext(i[31:20]).
  - STORE: sext{i[31:25],i[11:7]}.
  - BRANCH: sext{i[31],i[7],i[30:25],i[11:8],0}.
  - LUI/AUIPC: {i[31:12],12'b0}.
  - JAL: sext{i[31],i[19:12],i[20],i[30:21],0}.
  - CSR: {20'b0,i[31:20]}; the uimm is carried in `out_rs1`.
  - R/SYSCALL/FENCE/ILLEGAL: 0, with `imm_valid`=0.
- `rd_valid`: R, I, LOAD, JAL, JALR, LUI, AUIPC and CSR, and only when rd ≠ 0.
- `rs1_valid`:
  - R, I, LOAD, STORE, BRANCH, JALR: 1.
  - CSR: 1 only when funct3[2]=0.
- `rs2_valid`: R, STORE, BRANCH.
- Illegal conditions. Any one of these forces optype 15, `out_illegal`=1 and all valid flags 0:
  - i[1:0] ≠ 11, or an unknown opcode.
  - R: funct7 is not 0000000, or is 0100000 with funct3 ∉ {000,101}.
  - SLLI with funct7 ≠ 0.
  - SRLI/SRAI with funct7 ∉ {0000000,0100000}.
  - LOAD funct3 ∈ {011,110,111}.
  - STORE funct3 > 010.
  - BRANCH funct3 ∈ {010,011}.
  - JALR funct3 ≠ 0.
  - FENCE funct3 > 001.
  - CSR funct3 = 100.
  - SYSCALL with rd/rs1 ≠ 0 or imm ∉ {0,1}.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - A transfer occurs when `in_valid && in_ready`.
  - The output register holds steady while `out_valid && !out_ready`.

## Timing
- Latency: one cycle, accepted input to `out_valid`. Full throughput when `out_ready` is held high.
- Reset: `out_valid`=0, all payload outputs 0, `illegal_cnt`=0. Reset mid-transfer drops the held instruction.
- `flush`:
  - Next cycle `out_valid`=0.
  - The input in the flush cycle is not captured, although `in_ready` reads 1 that cycle.
  - `flush` has priority over a simultaneous capture.
- Simultaneous `out_ready` and a new input: the old entry leaves and the new one is captured in the same edge, with no bubble.
- Payload registers load only on capture, so they are stable while stalled.

## Configuration
- `QU_DECODER_ILLEGAL_CNT_EN` defined:
  - `illegal_cnt` port exists.
  - It increments by 1 on each accepted, non-flushed illegal instruction.
  - It saturates at 0xFFFFFFFF.
- Not defined: neither the port nor the counter logic exists.

## Structure
- Shared package additions: optype constants `OPTYPE_R` … `OPTYPE_ILLEGAL`, a packed `decoded_instr_t` struct carrying all payload outputs, and `imm32_t` reuse.
- Sub-module `qu_instr_decode_comb`: purely combinational word → `decoded_instr_t`. The top module adds the handshake register, flush and counter.

## Test plan
- `add x3,x1,x2`, 0x002081B3 → next cycle: optype 0, rd 3, rs1 1, rs2 2, rd/rs1/rs2_valid=1, imm_valid=0.
- `beq x1,x2,-4`, 0xFE208EE3 → optype 4, imm 0xFFFFFFFC, rs1_valid=rs2_valid=1, rd_valid=0.
- `lui x5,0x12345`, 0x123452B7 → optype 7, rd 5, imm 0x12345000, rs1_valid=0.
- 0x00000000, then 0x4000D033 (funct7 0100000 with funct3 101 on R is SRA, legal) → first: illegal=1 and illegal_cnt 1. Second: legal, optype 0.
- Back-to-back valid inputs with `out_ready`=0 for 2 cycles → `in_ready`=0 and outputs unchanged. `out_ready`=1 → one instruction per cycle, none lost or duplicated.
- `flush` asserted while `out_valid`=1 and `in_valid`=1 → `out_valid`=0 next cycle, flushed input never appears, counter unchanged.
